ntt_stage_sequencer: RTL and testbench

NTT_STAGE_SEQUENCER -- requirements
Module: ntt_stage_sequencer

---
 rtl/ntt_ctrl_pkg.sv | 17 +
 rtl/ntt_beat_counter.sv | 46 ++++
 rtl/ntt_stage_sequencer.sv | 137 +++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_ctrl_pkg.sv
// Shared types and widths for the NTT permutation-stage sequencer.
package ntt_ctrl_pkg;
    localparam int NUM_STAGES_DEF      = 9;
    localparam int BEATS_PER_FRAME_DEF = 8;
    localparam int TIMEOUT_CYCLES_DEF  = 64;

    localparam int STAGE_W = $clog2(NUM_STAGES_DEF);
    localparam int BEAT_W  = $clog2(BEATS_PER_FRAME_DEF);
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_ERR
    } seq_state_e;
endpackage

// File: rtl/ntt_beat_counter.sv
// Frame beat counter: a start pulse yields BEATS consecutive strobes with idx 0..BEATS-1.
module ntt_beat_counter
    import ntt_ctrl_pkg::*;
#(
    parameter int BEATS = BEATS_PER_FRAME_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              en,
    output logic [BEAT_W-1:0] idx,
    output logic              last
);
    logic              active_q, active_d;
    logic [BEAT_W-1:0] idx_q, idx_d;

    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        if (start) begin
            active_d = 1'b1;
            idx_d    = '0;
        end else if (active_q) begin
            if (idx_q == BEAT_W'(BEATS - 1)) begin
                active_d = 1'b0;
                idx_d    = '0;
            end else begin
                idx_d = idx_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            active_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
        end
    end

    assign en   = active_q;
    assign idx  = idx_q;
    assign last = active_q && (idx_q == BEAT_W'(BEATS - 1));
endmodule

// File: rtl/ntt_stage_sequencer.sv
// Sequences one frame through the chain of permutation stages with a per-stage watchdog.
module ntt_stage_sequencer
    import ntt_ctrl_pkg::*;
#(
    parameter int NUM_STAGES      = NUM_STAGES_DEF,
    parameter int BEATS_PER_FRAME = BEATS_PER_FRAME_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic                  load_en,
    output logic [BEAT_W-1:0]     beat_idx,
    output logic                  out_valid,
    output logic                  frame_done,
    output logic [STAGE_W-1:0]    cur_stage,
    output logic                  busy,
    output logic                  err,
    output logic [STAGE_W-1:0]    err_stage,
    input  logic                  err_clr
);
    seq_state_e            state_q, state_d;
    logic [STAGE_W-1:0]    cur_stage_q, cur_stage_d;
    logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  err_q, err_d;
    logic [STAGE_W-1:0]    err_stage_q, err_stage_d;
    logic [STAGE_W-1:0]    stage_nxt;
    logic                  load_go, drain_go;
    logic                  load_active, drain_active, drain_last, load_last_unused;
    logic [BEAT_W-1:0]     load_idx, drain_idx;

    always_comb begin
        state_d       = state_q;
        cur_stage_d   = cur_stage_q;
        stage_start_d = '0;
        wd_d          = wd_q;
        err_d         = err_q;
        err_stage_d   = err_stage_q;
        load_go       = 1'b0;
        drain_go      = 1'b0;
        stage_nxt     = cur_stage_q + STAGE_W'(1);
        unique case (state_q)
            ST_IDLE: begin
                if (frame_valid) begin
                    state_d          = ST_RUN;
                    cur_stage_d      = '0;
                    stage_start_d[0] = 1'b1;
                    wd_d             = '0;
                    load_go          = 1'b1;
                end
            end
            ST_RUN: begin
                wd_d = wd_q + WD_W'(1);
                // A done arriving on the expiry cycle takes priority over the timeout.
                if (stage_done[cur_stage_q]) begin
                    if (cur_stage_q == STAGE_W'(NUM_STAGES - 1)) begin
                        state_d  = ST_DRAIN;
                        drain_go = 1'b1;
                    end else begin
                        cur_stage_d   = stage_nxt;
                        stage_start_d = NUM_STAGES'(1) << stage_nxt;
                        wd_d          = '0;
                    end
                end else if (wd_q >= WD_W'(TIMEOUT_CYCLES)) begin
                    state_d     = ST_ERR;
                    err_d       = 1'b1;
                    err_stage_d = cur_stage_q;
                end
            end
            ST_DRAIN: begin
                if (drain_last) begin
                    state_d     = ST_IDLE;
                    cur_stage_d = '0;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cur_stage_q   <= '0;
            stage_start_q <= '0;
            wd_q          <= '0;
            err_q         <= 1'b0;
            err_stage_q   <= '0;
        end else begin
            state_q       <= state_d;
            cur_stage_q   <= cur_stage_d;
            stage_start_q <= stage_start_d;
            wd_q          <= wd_d;
            err_q         <= err_d;
            err_stage_q   <= err_stage_d;
        end
    end

    ntt_beat_counter #(.BEATS(BEATS_PER_FRAME)) u_load_cnt (
        .clk   (clk),
        .rst   (rst),
        .start (load_go),
        .en    (load_active),
        .idx   (load_idx),
        .last  (load_last_unused)
    );

    ntt_beat_counter #(.BEATS(BEATS_PER_FRAME)) u_drain_cnt (
        .clk   (clk),
        .rst   (rst),
        .start (drain_go),
        .en    (drain_active),
        .idx   (drain_idx),
        .last  (drain_last)
    );

    // The load counter keeps running after an abort; only its visible strobe is cut.
    assign load_en     = load_active && (state_q == ST_RUN);
    assign out_valid   = drain_active;
    assign frame_done  = drain_last;
    assign beat_idx    = load_en ? load_idx : (out_valid ? drain_idx : '0);
    assign frame_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign stage_start = stage_start_q;
    assign cur_stage   = cur_stage_q;
    assign err         = err_q;
    assign err_stage   = err_stage_q;
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench: timestamp-based reference model checked every cycle, plus directed scenario checks.
module tb_ntt_stage_sequencer;
    localparam int NS = 9, BPF = 8, TO = 64;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_ERR = 3;

    logic clk = 1'b0, rst = 1'b0, frame_valid = 1'b0, err_clr = 1'b0;
    logic [NS-1:0] stage_done = '0;
    logic frame_ready, load_en, out_valid, frame_done, busy, err;
    logic [NS-1:0] stage_start;
    logic [2:0] beat_idx;
    logic [3:0] cur_stage, err_stage;

    ntt_stage_sequencer #(.NUM_STAGES(NS), .BEATS_PER_FRAME(BPF), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .stage_start(stage_start), .stage_done(stage_done), .load_en(load_en),
        .beat_idx(beat_idx), .out_valid(out_valid), .frame_done(frame_done),
        .cur_stage(cur_stage), .busy(busy), .err(err), .err_stage(err_stage), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: mode plus timestamps of acceptance, last stage start and drain entry.
    int m_mode = M_IDLE, m_cur = 0, m_err = 0, m_err_stage = 0;
    int t_acc = -100, t_start = -100, t_drain = -100;
    bit m_rst = 1'b0;

    always @(posedge clk) begin
        m_rst = !rst;
        if (!rst) begin
            m_mode = M_IDLE; m_cur = 0; m_err = 0; m_err_stage = 0;
            t_acc = -100; t_start = -100; t_drain = -100;
        end else begin
            case (m_mode)
                M_IDLE: if (frame_valid) begin
                    m_mode = M_RUN; t_acc = cyc; m_cur = 0; t_start = cyc + 1;
                end
                M_RUN: if (stage_done[m_cur]) begin
                    if (m_cur == NS - 1) begin m_mode = M_DRAIN; t_drain = cyc; end
                    else begin m_cur++; t_start = cyc + 1; end
                end else if (cyc - t_start >= TO) begin
                    m_mode = M_ERR; m_err = 1; m_err_stage = m_cur;
                end
                M_DRAIN: if (cyc - t_drain == BPF) m_mode = M_IDLE;
                default: if (err_clr) begin m_mode = M_IDLE; m_err = 0; end
            endcase
        end
        cyc = cyc + 1;
    end

    // Stage responder configuration and event log.
    int dly [NS] = '{default: 5};
    int due [NS] = '{default: -1};
    int st_cyc [NS] = '{default: -1};
    bit spur_en = 1'b0;
    int spur_at = -1, spur_cur = -1;
    int fd_cnt = 0, fd_cyc = -1, ov_cnt = 0, ld_cnt = 0, acc_cyc = -1, err_cnt = 0, err_cyc = -1;
    logic err_d1 = 1'b0;
    logic [NS-1:0] e_start;
    bit e_load, e_ov, e_fd;
    int e_idx;

    always @(negedge clk) begin
        if (cyc > 0) begin
            e_start = (m_mode == M_RUN && t_start == cyc) ? (NS'(1) << m_cur) : '0;
            e_load  = (m_mode == M_RUN) && (cyc - t_acc >= 1) && (cyc - t_acc <= BPF);
            e_ov    = (m_mode == M_DRAIN);
            e_idx   = e_load ? cyc - t_acc - 1 : (e_ov ? cyc - t_drain - 1 : 0);
            e_fd    = e_ov && (cyc - t_drain == BPF);
            chk("frame_ready", frame_ready, m_mode == M_IDLE);
            chk("busy", busy, m_mode != M_IDLE);
            chk("stage_start", stage_start, e_start);
            chk("stage_start_onehot", $countones(stage_start) <= 1, 1);
            chk("load_en", load_en, e_load);
            chk("out_valid", out_valid, e_ov);
            chk("beat_idx", beat_idx, e_idx);
            chk("frame_done", frame_done, e_fd);
            chk("err", err, m_err);
            if (m_err != 0 || m_rst) chk("err_stage", err_stage, m_err_stage);
            if (m_mode == M_RUN || m_rst) chk("cur_stage", cur_stage, m_cur);
        end
        for (int s = 0; s < NS; s++) begin
            if (stage_start[s] === 1'b1) begin
                st_cyc[s] = cyc;
                if (dly[s] >= 0) due[s] = cyc + dly[s];
                if (spur_en && s == 1) spur_at = cyc + 3;
            end
        end
        if (frame_done === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
        if (out_valid === 1'b1) ov_cnt++;
        if (load_en === 1'b1) ld_cnt++;
        if (rst && frame_valid && frame_ready === 1'b1) acc_cyc = cyc;
        if (err === 1'b1) err_cnt++;
        if (err === 1'b1 && err_d1 !== 1'b1) err_cyc = cyc;
        err_d1 = err;
        if (cyc == spur_at + 1) spur_cur = cur_stage;
    end

    always @(posedge clk) begin
        #1;
        for (int s = 0; s < NS; s++) stage_done[s] = (due[s] == cyc);
        if (spur_at == cyc) stage_done[5] = 1'b1;
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic send_frame();
        @(posedge clk); #1 frame_valid = 1'b1;
        @(posedge clk); #1 frame_valid = 1'b0;
    endtask

    task automatic wait_fd(input int base, input int budget, input string name);
        int n = 0;
        while (fd_cnt == base && n < budget) begin tick(); n++; end
        if (fd_cnt == base) begin
            n_tot++;
            $display("FAIL %s: frame_done not seen within %0d cycles", name, budget);
        end
    endtask

    int base, ovb, ldb, errb, n;

    initial begin
        repeat (3) @(posedge clk);
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_load_en", load_en, 0);
        chk("rst_stage_start", stage_start, 0);
        chk("rst_cur_stage", cur_stage, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1 rst = 1'b1;
        tick();
        chk("release_ready", frame_ready, 1);

        // Normal frame, 5-cycle stage latency.
        base = fd_cnt; ovb = ov_cnt; ldb = ld_cnt;
        send_frame();
        wait_fd(base, 200, "normal_done");
        chk("normal_start0", st_cyc[0] - acc_cyc, 1);
        chk("normal_start4", st_cyc[4] - acc_cyc, 25);
        chk("normal_start8", st_cyc[8] - acc_cyc, 49);
        chk("normal_fd", fd_cyc - acc_cyc, 62);
        chk("normal_out_beats", ov_cnt - ovb, 8);
        chk("normal_load_beats", ld_cnt - ldb, 8);
        tick();
        chk("normal_idle", frame_ready, 1);

        // Back-to-back with frame_valid held high.
        base = fd_cnt;
        @(posedge clk); #1 frame_valid = 1'b1;
        wait_fd(base, 200, "b2b_first");
        n = fd_cyc;
        tick();
        chk("b2b_accept_gap", acc_cyc - n, 1);
        wait_fd(base + 1, 200, "b2b_second");
        @(posedge clk); #1 frame_valid = 1'b0;
        repeat (3) tick();

        // Done arriving on the watchdog expiry cycle.
        dly[2] = TO; base = fd_cnt; errb = err_cnt;
        send_frame();
        wait_fd(base, 400, "race_done");
        chk("race_no_err", err_cnt - errb, 0);
        chk("race_start3", st_cyc[3] - st_cyc[2], TO + 1);
        dly[2] = 5;

        // Spurious done for a stage not being awaited.
        dly[1] = 20; spur_en = 1'b1; base = fd_cnt;
        send_frame();
        wait_fd(base, 300, "spur_done");
        chk("spur_cur_stage", spur_cur, 1);
        chk("spur_start2", st_cyc[2] - st_cyc[1], 21);
        spur_en = 1'b0; dly[1] = 5;

        // Timeout on stage 3, then frame_valid ignored in ERR, then err_clr.
        dly[3] = -1; errb = err_cnt;
        send_frame();
        n = 0;
        while (err_cnt == errb && n < 300) begin tick(); n++; end
        if (err_cnt == errb) begin n_tot++; $display("FAIL timeout_err: err not raised within 300 cycles"); end
        chk("timeout_latency", err_cyc - st_cyc[3], TO + 1);
        chk("timeout_err_stage", err_stage, 3);
        frame_valid = 1'b1;
        repeat (4) tick();
        chk("err_ignores_valid", busy, 1);
        chk("err_sticky", err, 1);
        @(posedge clk); #1 frame_valid = 1'b0; err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        tick();
        chk("clr_ready", frame_ready, 1);
        chk("clr_err", err, 0);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        tick();
        chk("clr_in_idle", frame_ready, 1);
        dly[3] = 5;

        // Reset mid-drain at beat 4.
        base = fd_cnt;
        send_frame();
        n = 0;
        while (!(out_valid === 1'b1 && beat_idx == 3'd4) && n < 200) begin tick(); n++; end
        if (n >= 200) begin n_tot++; $display("FAIL drain_beat4: beat 4 not reached"); end
        rst = 1'b0;
        tick();
        chk("rst_drain_out_valid", out_valid, 0);
        chk("rst_drain_busy", busy, 0);
        chk("rst_drain_beat_idx", beat_idx, 0);
        chk("rst_drain_frame_done", frame_done, 0);
        @(posedge clk); #1 rst = 1'b1;
        tick();
        chk("rst_drain_ready", frame_ready, 1);
        repeat (10) tick();
        chk("rst_drain_no_fd", fd_cnt - base, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
